// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall detection and EX operand-forward selects; HAZ_STALL_CNT_EN adds a stall counter
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush_i,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall_o
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic              ex_v, ex_rw, ex_mr;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              mem_v, mem_rw, mem_mr;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_v, wb_rw;
    logic [REG_AW-1:0] wb_rd;

    logic mem_alu_producer;
    logic wb_producer;
    logic ex_load_producer;

    // A load sitting in MEM has no data yet, so it is never a MEM-stage forward source.
    assign mem_alu_producer = mem_v && mem_rw && !mem_mr && (mem_rd != '0);
    assign wb_producer      = wb_v && wb_rw && (wb_rd != '0);
    assign ex_load_producer = ex_v && ex_rw && ex_mr && (ex_rd != '0);

    always_comb begin
        ForwardA = FWD_RF;
        if (ex_v && mem_alu_producer && (mem_rd == ex_rs1))
            ForwardA = FWD_MEM;
        else if (ex_v && wb_producer && (wb_rd == ex_rs1))
            ForwardA = FWD_WB;
    end

    always_comb begin
        ForwardB = FWD_RF;
        if (ex_v && mem_alu_producer && (mem_rd == ex_rs2))
            ForwardB = FWD_MEM;
        else if (ex_v && wb_producer && (wb_rd == ex_rs2))
            ForwardB = FWD_WB;
    end

    // rs2 is matched even for instructions that ignore it; the extra stall is harmless.
    assign stall_o = id_valid && ex_load_producer && !flush_i &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v   <= 1'b0;
            ex_rw  <= 1'b0;
            ex_mr  <= 1'b0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_rw <= 1'b0;
            mem_mr <= 1'b0;
            mem_rd <= '0;
            wb_v   <= 1'b0;
            wb_rw  <= 1'b0;
            wb_rd  <= '0;
        end else begin
            wb_v   <= mem_v;
            wb_rw  <= mem_rw;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rw <= ex_rw;
            mem_mr <= ex_mr;
            mem_rd <= ex_rd;
            if (flush_i || stall_o) begin
                ex_v   <= 1'b0;
                ex_rw  <= 1'b0;
                ex_mr  <= 1'b0;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
                ex_rd  <= '0;
            end else begin
                ex_v   <= id_valid;
                ex_rw  <= id_regwrite;
                ex_mr  <= id_memread;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
                ex_rd  <= id_rd;
            end
        end
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_o)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vector table plus random run against a pipeline-history model
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread;
    logic       flush_i;
    logic [1:0] ForwardA, ForwardB;
    logic       stall_o;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush_i(flush_i),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_o(stall_o)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       rw, mr;
    } instr_t;

    typedef struct {
        bit       rst;
        instr_t   id;
        bit       flush;
        bit [1:0] fa, fb;
        bit       st;
        int       cnt;
    } vec_t;

    // Model: list of instructions by age; index 0 = EX, 1 = MEM, 2 = WB.
    instr_t hist[$];
    int     m_cnt;

    function automatic instr_t ins(bit v, int rs1, int rs2, int rd, bit rw, bit mr);
        instr_t i;
        i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd); i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic bit is_producer(instr_t i);
        return i.v && i.rw && (i.rd != 0);
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] src);
        if (!hist[0].v) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (is_producer(hist[age]) && hist[age].rd == src) begin
                if (age == 1 && hist[age].mr) continue;
                return (age == 1) ? 2'b10 : 2'b01;
            end
        end
        return 2'b00;
    endfunction

    function automatic bit m_stall(instr_t id, bit flush);
        instr_t e = hist[0];
        return id.v && is_producer(e) && e.mr && !flush && (e.rd == id.rs1 || e.rd == id.rs2);
    endfunction

    task automatic m_clear();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(ins(0, 0, 0, 0, 0, 0));
        m_cnt = 0;
    endtask

    task automatic check(string name, int idx, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic drive(bit r, instr_t id, bit fl);
        rst = r; flush_i = fl;
        id_valid = id.v; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        id_regwrite = id.rw; id_memread = id.mr;
    endtask

    // Advance model across the active edge using the currently applied inputs.
    task automatic edge_step(bit r, instr_t id, bit fl);
        bit st = m_stall(id, fl);
        @(posedge clk);
        if (r) m_clear();
        else begin
            if (st) m_cnt = m_cnt + 1;
            hist.push_front((fl || st) ? ins(0, 0, 0, 0, 0, 0) : id);
            void'(hist.pop_back());
        end
    endtask

    task automatic cnt_check(string name, int idx, int want);
`ifdef HAZ_STALL_CNT_EN
        check(name, idx, int'(stall_cnt), want);
`endif
    endtask

    vec_t   tbl[$];
    instr_t nop;

    task automatic add(bit r, instr_t id, bit fl, bit [1:0] fa, bit [1:0] fb, bit st, int cnt);
        vec_t t;
        t.rst = r; t.id = id; t.flush = fl; t.fa = fa; t.fb = fb; t.st = st; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    initial begin
        nop = ins(0, 0, 0, 0, 0, 0);
        m_clear();
        drive(1, nop, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, nop, 0);
        #1;
        check("reset_fa", -1, ForwardA, 0);
        check("reset_fb", -1, ForwardB, 0);
        check("reset_stall", -1, stall_o, 0);
        cnt_check("reset_cnt", -1, 0);

        // ALU back-to-back
        add(0, ins(1, 1, 2, 5, 1, 0), 0, 0, 0, 0, 0);
        add(0, ins(1, 5, 5, 6, 1, 0), 0, 0, 0, 0, 0);
        add(0, nop, 0, 2'b10, 2'b10, 0, 0);
        add(0, nop, 0, 0, 0, 0, 0);
        add(0, nop, 0, 0, 0, 0, 0);
        // gap of one
        add(0, ins(1, 1, 2, 5, 1, 0), 0, 0, 0, 0, 0);
        add(0, nop, 0, 0, 0, 0, 0);
        add(0, ins(1, 5, 1, 7, 1, 0), 0, 0, 0, 0, 0);
        add(0, nop, 0, 2'b01, 2'b00, 0, 0);
        add(0, nop, 0, 0, 0, 0, 0);
        // load-use on rs1
        add(0, ins(1, 3, 4, 8, 1, 1), 0, 0, 0, 0, 0);
        add(0, ins(1, 8, 2, 9, 1, 0), 0, 0, 0, 1, 0);
        add(0, ins(1, 8, 2, 9, 1, 0), 0, 0, 0, 0, 1);
        add(0, nop, 0, 2'b01, 2'b00, 0, 1);
        add(0, nop, 0, 0, 0, 0, 1);
        // x0 writers
        add(0, ins(1, 1, 2, 0, 1, 0), 0, 0, 0, 0, 1);
        add(0, ins(1, 0, 0, 3, 1, 0), 0, 0, 0, 0, 1);
        add(0, ins(1, 1, 2, 0, 1, 1), 0, 0, 0, 0, 1);
        add(0, ins(1, 0, 0, 4, 1, 0), 0, 0, 0, 0, 1);
        add(0, nop, 0, 0, 0, 0, 1);
        add(0, nop, 0, 0, 0, 0, 1);
        // flush beats load-use
        add(0, ins(1, 3, 4, 8, 1, 1), 0, 0, 0, 0, 1);
        add(0, ins(1, 8, 2, 9, 1, 0), 1, 0, 0, 0, 1);
        add(0, nop, 0, 0, 0, 0, 1);
        // load-use on rs2 only
        add(0, ins(1, 1, 1, 10, 1, 1), 0, 0, 0, 0, 1);
        add(0, ins(1, 1, 10, 11, 1, 0), 0, 0, 0, 1, 1);
        add(0, ins(1, 1, 10, 11, 1, 0), 0, 0, 0, 0, 2);
        add(0, nop, 0, 2'b00, 2'b01, 0, 2);
        // MEM beats WB for the same rd
        add(0, ins(1, 1, 2, 12, 1, 0), 0, 0, 0, 0, 2);
        add(0, ins(1, 1, 2, 12, 1, 0), 0, 0, 0, 0, 2);
        add(0, ins(1, 12, 12, 13, 1, 0), 0, 0, 0, 0, 2);
        add(0, nop, 0, 2'b10, 2'b10, 0, 2);
        // reset while stalling
        add(0, ins(1, 1, 2, 14, 1, 1), 0, 0, 0, 0, 2);
        add(1, ins(1, 14, 14, 15, 1, 0), 0, 0, 0, 1, 2);
        add(0, ins(1, 14, 14, 15, 1, 0), 0, 0, 0, 0, 0);
        add(0, nop, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].id, tbl[i].flush);
            #1;
            check("tbl_fa", i, ForwardA, tbl[i].fa);
            check("tbl_fb", i, ForwardB, tbl[i].fb);
            check("tbl_stall", i, stall_o, tbl[i].st);
            cnt_check("tbl_cnt", i, tbl[i].cnt);
            edge_step(tbl[i].rst, tbl[i].id, tbl[i].flush);
        end

        for (int i = 0; i < 3000; i++) begin
            instr_t id;
            bit r, fl;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 15) == 0);
            id = ins($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            @(negedge clk);
            drive(r, id, fl);
            #1;
            check("rnd_fa", i, ForwardA, m_fwd(hist[0].rs1));
            check("rnd_fb", i, ForwardB, m_fwd(hist[0].rs2));
            check("rnd_stall", i, stall_o, m_stall(id, fl));
            cnt_check("rnd_cnt", i, m_cnt);
            edge_step(r, id, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
